ham_encoder_tx: RTL and testbench
=================================

HAM_ENCODER_TX -- requirements
Module: ham_encoder_tx

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous active-high reset, with ports named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-004 data  input  4  nibble to encode.
REQ-005 data_valid  input  1  data (and inject_pos) offered this cycle.
REQ-006 data_ready  output  1  block accepts data this cycle.
REQ-007 inject_pos  input  3  error-injection position: 0 = none; 1..7 = flip codeword bit (inject_pos-1).
REQ-008 serial_out  output  1  current transmitted codeword bit.
REQ-009 serial_valid  output  1  serial_out carries a live bit.
REQ-010 frame_start  output  1  high during bit 0 of each frame.
REQ-011 codeword  output  7  codeword most recently loaded for transmission, injection included.
REQ-012 frame_count  output  8  count of completed frames; wraps 255 -> 0.

Function
REQ-013 Encoding SHALL match the team decoder's bit map, with data bits at idx2, 4, 5, 6 and parity bits at idx0, 1, 3:
- c[2]=d[0], c[4]=d[1], c[5]=d[2], c[6]=d[3]
- c[0]=d0^d1^d3, c[1]=d0^d2^d3, c[3]=d1^d2^d3
REQ-014 A transfer SHALL occur on any edge where data_valid && data_ready; encoding and injection SHALL be applied at that edge.
REQ-015 When 1<=inject_pos<=7, the stored codeword SHALL be c with bit (inject_pos-1) inverted; exactly one bit is flipped.
REQ-016 The FSM SHALL have two states:
- IDLE: serial_valid=0, serial_out=0.
- SEND: holds shift register sr[6:0] and bit_cnt 0..6.
REQ-017 In SEND, serial_out SHALL equal sr[bit_cnt] (LSB first) and serial_valid SHALL be 1; bit_cnt increments each cycle.
REQ-018 A one-entry holding buffer (buf, buf_full) SHALL exist, and data_ready SHALL equal !buf_full, registered-state driven with no combinational path from data_valid.
REQ-019 An accepted word SHALL load sr directly when:
- state is IDLE, or
- state is SEND, bit_cnt==6, and buf_full==0.
In all other cases the word SHALL be stored in buf.
REQ-020 At the edge ending bit 6:
- frame_count SHALL increment.
- If buf_full (or a direct load per REQ-019 occurs), sr SHALL load the next word, bit_cnt SHALL reset to 0, and the FSM SHALL stay in SEND with no idle gap.
- Otherwise the FSM SHALL go to IDLE.
REQ-021 A buffer drain and a new acceptance SHALL NOT occur on the same edge, because data_ready=0 whenever buf_full=1.
REQ-022 codeword SHALL update on every sr load and hold otherwise.
REQ-023 Latency: data accepted at edge T SHALL produce frame_start=1 and bit 0 in the cycle after T when loaded directly; 7 cycles per frame.
REQ-024 frame_start SHALL equal (state==SEND && bit_cnt==0).
REQ-025 frame_count SHALL increment by exactly 1 per 7-bit frame, modulo 256.

Reset
REQ-026 reset SHALL take priority over all other inputs, including mid-frame and mid-acceptance.
REQ-027 On reset, the block SHALL enter the following state:
- state=IDLE, bit_cnt=0, sr=0, buf_full=0.
- serial_out=0, serial_valid=0, frame_start=0.
- codeword=0, frame_count=0.
- data_ready=1 in the first cycle after reset.
REQ-028 A frame interrupted by reset SHALL be discarded, and frame_count SHALL NOT increment for it.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Single frame: data=4'b1011, inject_pos=0 -> codeword=7'b1010101; serial bits 1,0,1,0,1,0,1 over 7 cycles; frame_start on bit 0 only; frame_count=1; then IDLE.
- Exhaustive: all 16 nibbles, each frame looped through the team's Hamming decoder -> decoded data equals input.
  - Spot values: 4'h0 -> 7'b0000000, 4'hF -> 7'b1111111, 4'b0001 -> 7'b0000111.
- Injection: data=4'b1011, inject_pos=3 -> codeword=7'b1010001; decoder corrects to 7'b1010101.
  - Also sweep inject_pos 1..7 for a single-bit flip at each position.
- Back-to-back: data_valid held high with 3 words -> 21 consecutive serial_valid cycles with no gap.
  - data_ready drops while buf_full; frame_count=3.
- Reset mid-frame: reset asserted at bit 4 -> next cycle serial_valid=0, codeword=0, frame_count=0, data_ready=1.
  - A subsequent word transmits cleanly.
- Wrap: 256 frames -> frame_count returns to 0.

Source files
------------

// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) encoder with single-bit error injection, serialising each
// codeword LSB first behind a one-entry holding buffer so frames can run back to back.
module ham_encoder_tx (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] data,
   input  logic       data_valid,
   output logic       data_ready,
   input  logic [2:0] inject_pos,
   output logic       serial_out,
   output logic       serial_valid,
   output logic       frame_start,
   output logic [6:0] codeword,
   output logic [7:0] frame_count
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t     state;
   logic [6:0] sr;
   logic [6:0] hold_buf;
   logic       buf_full;
   logic [2:0] bit_cnt;

   logic [6:0] enc;
   logic [6:0] inj_mask;
   logic [6:0] new_word;
   logic       accept;

   // Data bits sit at 2,4,5,6 and parity at 0,1,3, matching the team decoder.
   always_comb begin
      enc[2]   = data[0];
      enc[4]   = data[1];
      enc[5]   = data[2];
      enc[6]   = data[3];
      enc[0]   = data[0] ^ data[1] ^ data[3];
      enc[1]   = data[0] ^ data[2] ^ data[3];
      enc[3]   = data[1] ^ data[2] ^ data[3];
      inj_mask = '0;
      if (inject_pos != 3'd0)
         inj_mask = 7'd1 << (inject_pos - 3'd1);
      new_word = enc ^ inj_mask;
   end

   // Readiness depends only on the buffer flop, so a drain and an accept never coincide.
   assign data_ready   = !buf_full;
   assign accept       = data_valid && !buf_full;
   assign serial_valid = (state == SEND);
   assign serial_out   = serial_valid && sr[bit_cnt];
   assign frame_start  = serial_valid && (bit_cnt == 3'd0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         sr          <= '0;
         hold_buf    <= '0;
         buf_full    <= 1'b0;
         bit_cnt     <= '0;
         codeword    <= '0;
         frame_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sr       <= new_word;
                  codeword <= new_word;
                  bit_cnt  <= '0;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (bit_cnt == 3'd6) begin
                  // Last bit of the frame: chain straight into the next word if one is available.
                  frame_count <= frame_count + 8'd1;
                  bit_cnt     <= '0;
                  if (buf_full) begin
                     sr       <= hold_buf;
                     codeword <= hold_buf;
                     buf_full <= 1'b0;
                  end else if (accept) begin
                     sr       <= new_word;
                     codeword <= new_word;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (accept) begin
                     hold_buf <= new_word;
                     buf_full <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Scoreboard bench for ham_encoder_tx: stimulus pushes expected frames, a
// negedge monitor pops them and checks codeword, decoder result and every serial bit.
module tb_ham_encoder_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] data = '0;
   logic       data_valid = 1'b0;
   logic [2:0] inject_pos = '0;
   logic       data_ready;
   logic       serial_out;
   logic       serial_valid;
   logic       frame_start;
   logic [6:0] codeword;
   logic [7:0] frame_count;

   ham_encoder_tx dut (
      .clock        (clock),
      .reset        (reset),
      .data         (data),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .inject_pos   (inject_pos),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .frame_start  (frame_start),
      .codeword     (codeword),
      .frame_count  (frame_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [6:0] cw;
      logic [6:0] clean;
      logic [3:0] data;
   } exp_t;

   // Hand-computed clean codewords for nibbles 0..F.
   logic [6:0] cwTable [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

   exp_t       expQ[$];
   exp_t       cur = '0;
   logic [6:0] corr;
   int         errors = 0;
   int         checks = 0;
   int         bitIdx = 0;
   int         runLen = 0;
   int         lastRun = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s at %0t", name, $time);
   endtask

   // Syndrome decoder in the team layout; returns the corrected codeword.
   function automatic logic [6:0] hamCorrect(input logic [6:0] c);
      logic [6:0] r;
      logic [2:0] s;
      r    = c;
      s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
      s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
      s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
      if (s != 3'd0)
         r[s - 3'd1] = ~r[s - 3'd1];
      return r;
   endfunction

   // Monitor: frame boundaries come from the bench's own bit count, not from the DUT.
   always @(negedge clock) begin
      if (serial_valid) begin
         runLen++;
         if (bitIdx == 0 || bitIdx == 7) begin
            checkOutput("frame_start on bit 0", frame_start, 1);
            if (expQ.size() == 0) begin
               failNow("unexpected frame");
               cur = '0;
            end else begin
               cur  = expQ.pop_front();
               corr = hamCorrect(codeword);
               checkOutput("codeword", codeword, cur.cw);
               checkOutput("decoder corrected", corr, cur.clean);
               checkOutput("decoded data", {corr[6:4], corr[2]}, cur.data);
            end
            bitIdx = 0;
         end else begin
            checkOutput("frame_start off bit 0", frame_start, 0);
         end
         checkOutput("serial_out bit", serial_out, cur.cw[bitIdx]);
         bitIdx++;
      end else begin
         if (runLen > 0) lastRun = runLen;
         runLen = 0;
         checkOutput("frame_start while idle", frame_start, 0);
         if (bitIdx > 0 && bitIdx < 7) begin
            failNow("frame truncated");
            bitIdx = 0;
         end
      end
      if (reset) begin
         bitIdx = 0;
         runLen = 0;
      end
   end

   task automatic applyStimulus(input logic [3:0] d, input logic [2:0] inj);
      int   waitCnt;
      exp_t e;
      waitCnt = 0;
      @(negedge clock);
      while (!data_ready && waitCnt < 50) begin
         @(negedge clock);
         waitCnt++;
      end
      if (!data_ready) begin
         failNow("data_ready timeout");
      end else begin
         data       = d;
         inject_pos = inj;
         data_valid = 1'b1;
         e.clean    = cwTable[d];
         e.cw       = (inj == 3'd0) ? e.clean : (e.clean ^ (7'd1 << (inj - 3'd1)));
         e.data     = d;
         expQ.push_back(e);
         @(posedge clock);
      end
   endtask

   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      @(negedge clock);
      data_valid = 1'b0;
      inject_pos = '0;
      while ((expQ.size() != 0 || serial_valid) && n < limit) begin
         @(negedge clock);
         n++;
      end
      if (expQ.size() != 0 || serial_valid) failNow("idle timeout");
      @(negedge clock);
   endtask

   task automatic doReset();
      @(negedge clock);
      reset      = 1'b1;
      data_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      doReset();
      checkOutput("reset serial_valid", serial_valid, 0);
      checkOutput("reset serial_out", serial_out, 0);
      checkOutput("reset frame_start", frame_start, 0);
      checkOutput("reset codeword", codeword, 0);
      checkOutput("reset frame_count", frame_count, 0);
      checkOutput("reset data_ready", data_ready, 1);

      // Single frame 1011 -> 1010101
      applyStimulus(4'b1011, 3'd0);
      waitIdle(50);
      checkOutput("single frame_count", frame_count, 1);
      checkOutput("single idle serial_valid", serial_valid, 0);
      checkOutput("single idle serial_out", serial_out, 0);
      checkOutput("single data_ready", data_ready, 1);

      // Every nibble through the decoder
      for (int i = 0; i < 16; i++) applyStimulus(4'(i), 3'd0);
      waitIdle(200);
      checkOutput("exhaustive frame_count", frame_count, 17);

      // Injection at position 3, then a sweep of all positions
      applyStimulus(4'b1011, 3'd3);
      for (int p = 1; p <= 7; p++) applyStimulus(4'h6, 3'(p));
      waitIdle(200);
      checkOutput("inject frame_count", frame_count, 25);
      checkOutput("inject last codeword", codeword, 7'h73);

      // Back-to-back: three words with valid held high
      doReset();
      applyStimulus(4'hA, 3'd0);
      applyStimulus(4'h5, 3'd0);
      #1;
      checkOutput("data_ready while buf_full", data_ready, 0);
      applyStimulus(4'hC, 3'd0);
      waitIdle(100);
      checkOutput("b2b serial_valid run", lastRun, 21);
      checkOutput("b2b frame_count", frame_count, 3);

      // Reset during bit 4
      applyStimulus(4'h9, 3'd0);
      @(negedge clock);
      data_valid = 1'b0;
      repeat (4) @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("midreset serial_valid", serial_valid, 0);
      checkOutput("midreset codeword", codeword, 0);
      checkOutput("midreset frame_count", frame_count, 0);
      checkOutput("midreset data_ready", data_ready, 1);
      reset = 1'b0;
      applyStimulus(4'h3, 3'd0);
      waitIdle(50);
      checkOutput("post-reset frame_count", frame_count, 1);

      // 256 frames wrap the counter
      doReset();
      for (int i = 0; i < 256; i++) applyStimulus(4'(i), 3'd0);
      waitIdle(300);
      checkOutput("wrap frame_count", frame_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog timeout");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] watchdog");
   end

endmodule
